wb_arbiter2: RTL and testbench



---
 rtl/wb_arbiter2.sv | 173 +++++++++++++++++
 tb/tb_wb_arbiter2.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// Two-master / one-slave Wishbone B4 pipelined arbiter (instr = m0, data = m1).
// Optional macro WB_ARB_ROUND_ROBIN_EN: round-robin tie break instead of data-first.
module wb_arbiter2 #(
    parameter int MaxOutstanding = 4,
    parameter int TimeoutCycles  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  m_cyc,
    input  logic [1:0]  m_stb,
    input  logic [1:0]  m_we,
    input  logic [7:0]  m_sel,
    input  logic [63:0] m_adr,
    input  logic [63:0] m_dat_w,
    output logic [31:0] m_dat_r,
    output logic [1:0]  m_ack,
    output logic [1:0]  m_err,
    output logic [1:0]  m_stall,
    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [3:0]  s_sel,
    output logic [31:0] s_adr,
    output logic [31:0] s_dat_w,
    input  logic [31:0] s_dat_r,
    input  logic        s_ack,
    input  logic        s_err,
    input  logic        s_stall
);

    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CntW-1:0] outstanding;
    logic [CntW-1:0] outstanding_next;
    logic            granted;
    logic            sel;
    logic            cyc_n;
    logic            at_limit;
    logic            has_out;
    logic            resp;
    logic            timeout;
    logic            winner;

    assign granted  = (state != IDLE);
    assign sel      = (state == GNT1);
    assign cyc_n    = sel ? m_cyc[1] : m_cyc[0];
    assign at_limit = (outstanding == MaxCnt);
    assign has_out  = (outstanding != '0);
    // a response with nothing pending is stale and must be dropped
    assign resp     = (s_ack | s_err) & has_out;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic last;

    assign winner = (m_cyc == 2'b11) ? ~last : m_cyc[1];

    // remember the last grant so the other master wins the next tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b0;
        end else if (state == IDLE && m_cyc != 2'b00) begin
            last <= winner;
        end
    end
`else
    assign winner = m_cyc[1];
`endif

    if (TimeoutCycles > 0) begin : g_wd
        localparam int WdW = $clog2(TimeoutCycles + 1);
        logic [WdW-1:0] wd_cnt;

        assign timeout = granted & cyc_n & ~(s_ack | s_err)
                       & (wd_cnt == WdW'(TimeoutCycles));

        // count clocks spent waiting on a response while transfers are pending
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wd_cnt <= '0;
            end else if (!granted || !cyc_n || timeout || s_ack || s_err || !has_out) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end else begin : g_no_wd
        assign timeout = 1'b0;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state: grant from IDLE only, release on CYC drop or watchdog
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (m_cyc != 2'b00) begin
                    state_next = winner ? GNT1 : GNT0;
                end
            end
            GNT0, GNT1: begin
                if (!cyc_n || timeout) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // output mux: only the granted master reaches the slave
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_sel   = 4'h0;
        s_adr   = 32'h0;
        s_dat_w = 32'h0;
        m_dat_r = 32'h0;
        m_ack   = 2'b00;
        m_err   = 2'b00;
        m_stall = 2'b11;
        if (granted) begin
            s_cyc   = cyc_n & ~timeout;
            s_stb   = cyc_n & (sel ? m_stb[1] : m_stb[0]) & ~at_limit & ~timeout;
            s_we    = sel ? m_we[1] : m_we[0];
            s_sel   = sel ? m_sel[7:4] : m_sel[3:0];
            s_adr   = sel ? m_adr[63:32] : m_adr[31:0];
            s_dat_w = sel ? m_dat_w[63:32] : m_dat_w[31:0];
            m_dat_r = s_dat_r;
            m_stall[sel] = s_stall | at_limit | timeout;
            m_ack[sel]   = s_ack & has_out;
            m_err[sel]   = (s_err & has_out) | timeout;
        end
    end

    // outstanding count: cleared whenever the grant ends
    always_comb begin
        outstanding_next = outstanding;
        if (state_next == IDLE) begin
            outstanding_next = '0;
        end else if ((s_stb & ~s_stall) && !resp) begin
            outstanding_next = outstanding + 1'b1;
        end else if (!(s_stb & ~s_stall) && resp) begin
            outstanding_next = outstanding - 1'b1;
        end
    end

    // outstanding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding_next;
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 (MaxOutstanding = 4, TimeoutCycles = 16).
// Cycle vectors from a table plus hand sequences for burst/watchdog/abort/reset.
module tb_wb_arbiter2;

    localparam int TO = 16;
    localparam logic [31:0] RD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  m_cyc = 2'b11;
    logic [1:0]  m_stb = 2'b00;
    logic [1:0]  m_we = 2'b10;
    logic [7:0]  m_sel = 8'hF3;
    logic [63:0] m_adr = {32'h0000_0200, 32'h0000_0100};
    logic [63:0] m_dat_w = {32'h2222_2222, 32'h1111_1111};
    logic [31:0] m_dat_r;
    logic [1:0]  m_ack, m_err, m_stall;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_dat_w;
    logic [31:0] s_dat_r = RD;
    logic        s_ack = 1'b0;
    logic        s_err = 1'b0;
    logic        s_stall = 1'b0;

    int checks = 0;
    int errors = 0;

    wb_arbiter2 #(.MaxOutstanding(4), .TimeoutCycles(TO)) dut (
        .clk(clk), .rst(rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r),
        .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r),
        .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic        ack;
        logic        e_cyc;
        logic        e_stb;
        logic        e_we;
        logic [31:0] e_adr;
        logic [1:0]  e_ack;
        logic [1:0]  e_stall;
        logic [31:0] e_dat;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic add(input logic [1:0] cyc, input logic [1:0] stb, input logic ack,
                       input logic ec, input logic es, input logic ew,
                       input logic [31:0] ea, input logic [1:0] ek,
                       input logic [1:0] est, input logic [31:0] ed);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.ack = ack;
        v.e_cyc = ec; v.e_stb = es; v.e_we = ew; v.e_adr = ea;
        v.e_ack = ek; v.e_stall = est; v.e_dat = ed;
        tbl.push_back(v);
    endtask

    task automatic step(input logic [1:0] cyc, input logic [1:0] stb, input logic ack);
        @(posedge clk); #1;
        m_cyc = cyc; m_stb = stb; s_ack = ack;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [7:0] pipe;
        int sent, acks, outm;
        logic saw, acc, win;

        // single read by master 0, ack two clocks after the strobe
        add(2'b01, 2'b01, 0, 0, 0, 0, 32'h0,   2'b00, 2'b11, 32'h0);
        add(2'b01, 2'b01, 0, 1, 1, 0, 32'h100, 2'b00, 2'b10, RD);
        add(2'b01, 2'b00, 0, 1, 0, 0, 32'h100, 2'b00, 2'b10, RD);
        add(2'b01, 2'b00, 1, 1, 0, 0, 32'h100, 2'b01, 2'b10, RD);
        add(2'b00, 2'b00, 0, 0, 0, 0, 32'h100, 2'b00, 2'b10, RD);
        add(2'b00, 2'b00, 0, 0, 0, 0, 32'h0,   2'b00, 2'b11, 32'h0);
        // both request together: data master first, instr after one idle clock
        add(2'b11, 2'b11, 0, 0, 0, 0, 32'h0,   2'b00, 2'b11, 32'h0);
        add(2'b11, 2'b11, 0, 1, 1, 1, 32'h200, 2'b00, 2'b01, RD);
        add(2'b11, 2'b01, 1, 1, 0, 1, 32'h200, 2'b10, 2'b01, RD);
        add(2'b01, 2'b01, 0, 0, 0, 1, 32'h200, 2'b00, 2'b01, RD);
        add(2'b01, 2'b01, 0, 0, 0, 0, 32'h0,   2'b00, 2'b11, 32'h0);
        add(2'b01, 2'b01, 0, 1, 1, 0, 32'h100, 2'b00, 2'b10, RD);
        add(2'b01, 2'b00, 1, 1, 0, 0, 32'h100, 2'b01, 2'b10, RD);
        add(2'b00, 2'b00, 0, 0, 0, 0, 32'h100, 2'b00, 2'b10, RD);
        add(2'b00, 2'b00, 0, 0, 0, 0, 32'h0,   2'b00, 2'b11, 32'h0);

        // reset state, with both masters requesting
        @(negedge clk);
        chk("reset_state", {s_cyc, s_stb, m_ack, m_err, m_stall, s_adr, m_dat_r},
            {1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 32'h0, 32'h0});
        m_cyc = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].cyc, tbl[i].stb, tbl[i].ack);
            chk($sformatf("vec%0d", i),
                {s_cyc, s_stb, s_we, s_adr, m_ack, m_err, m_stall, m_dat_r},
                {tbl[i].e_cyc, tbl[i].e_stb, tbl[i].e_we, tbl[i].e_adr,
                 tbl[i].e_ack, 2'b00, tbl[i].e_stall, tbl[i].e_dat});
        end

        // four repeated contentions
        for (int k = 0; k < 4; k++) begin
            step(2'b11, 2'b00, 0);
            step(2'b11, 2'b00, 0);
`ifdef WB_ARB_ROUND_ROBIN_EN
            win = (k % 2 == 0);
`else
            win = 1'b1;
`endif
            chk($sformatf("contend%0d", k), m_stall, win ? 2'b01 : 2'b10);
            step(2'b00, 2'b00, 0);
        end

        // master 1 burst of six, slave acks five clocks after acceptance
        step(2'b10, 2'b00, 0);
        chk("burst_arb", m_stall, 2'b11);
        pipe = '0; sent = 0; acks = 0; outm = 0; saw = 1'b0;
        for (int t = 0; t < 20; t++) begin
            step(2'b10, (sent < 6) ? 2'b10 : 2'b00, pipe[4]);
            chk($sformatf("burst_stall%0d", t), {m_err, m_stall},
                {2'b00, outm == 4, 1'b1});
            if (m_stall[1] && m_stb[1]) saw = 1'b1;
            if (m_ack[1]) acks++;
            acc = (sent < 6) && (outm < 4);
            sent += int'(acc);
            outm = outm + int'(acc) - int'(s_ack);
            pipe = {pipe[6:0], acc};
        end
        chk("burst_limit_hit", saw, 1'b1);
        chk("burst_acks", acks, 6);
        step(2'b00, 2'b00, 0);
        step(2'b00, 2'b00, 0);

        // watchdog: one accepted strobe, slave silent
        step(2'b01, 2'b01, 0);
        chk("wd_arb", m_stall, 2'b11);
        step(2'b01, 2'b01, 0);
        chk("wd_accept", {s_stb, m_stall}, {1'b1, 2'b10});
        for (int k = 1; k <= TO; k++) begin
            step(2'b01, 2'b00, 0);
            chk($sformatf("wd_wait%0d", k), {s_cyc, m_err}, {1'b1, 2'b00});
        end
        step(2'b01, 2'b00, 0);
        chk("wd_err", {s_cyc, m_err}, {1'b0, 2'b01});
        step(2'b10, 2'b00, 0);
        chk("wd_idle", {s_cyc, m_err, m_stall}, {1'b0, 2'b00, 2'b11});
        step(2'b10, 2'b00, 0);
        chk("wd_other_grant", {s_cyc, m_stall}, {1'b1, 2'b01});
        step(2'b00, 2'b00, 0);
        step(2'b00, 2'b00, 0);

        // master 0 aborts with two transfers outstanding
        step(2'b01, 2'b01, 0);
        step(2'b01, 2'b01, 0);
        step(2'b01, 2'b01, 0);
        step(2'b00, 2'b00, 0);
        chk("abort_release", s_cyc, 1'b0);
        step(2'b00, 2'b00, 1);
        chk("abort_late_ack", {m_ack, m_stall}, {2'b00, 2'b11});
        step(2'b01, 2'b00, 0);
        step(2'b01, 2'b00, 1);
        chk("abort_stale_ack", {s_cyc, m_ack}, {1'b1, 2'b00});
        for (int k = 0; k < 5; k++) begin
            step(2'b01, 2'b01, 0);
            chk($sformatf("abort_fill%0d", k), m_stall, (k == 4) ? 2'b11 : 2'b10);
        end
        for (int k = 0; k < 4; k++) begin
            step(2'b01, 2'b00, 1);
            chk($sformatf("abort_drain%0d", k), m_ack, 2'b01);
        end
        step(2'b00, 2'b00, 0);
        step(2'b00, 2'b00, 0);

        // asynchronous reset in the middle of a burst
        step(2'b10, 2'b10, 0);
        step(2'b10, 2'b10, 0);
        step(2'b10, 2'b10, 1);
        chk("rst_before", {s_cyc, s_stb, m_ack, m_stall}, {1'b1, 1'b1, 2'b10, 2'b01});
        #1 rst = 1'b1;
        #1;
        chk("rst_async", {s_cyc, s_stb, m_ack, m_stall}, {1'b0, 1'b0, 2'b00, 2'b11});
        @(posedge clk); #1;
        s_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rearb", {s_cyc, m_stall}, {1'b0, 2'b11});
        step(2'b10, 2'b10, 0);
        chk("rst_regrant", {s_cyc, s_stb, m_stall}, {1'b1, 1'b1, 2'b01});
        step(2'b00, 2'b00, 0);
        step(2'b00, 2'b00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
